clint_multi: RTL and testbench

Parametrised multi-hart core-local interruptor for the SoC peripheral bus. It provides a shared 64-bit mtime counter, one msip bit per hart and one 64-bit mtimecmp per hart. The counter is advanced from the system clock through a programmable prescaler, so no separate RTC clock domain is needed. The block sits behind the AXI bridge on the simple peripheral (gpi) interface and drives the per-hart timer and software interrupt lines into the cores.

---
 rtl/clint_pkg.sv | 28 ++
 rtl/clint_timebase.sv | 30 +++
 rtl/clint_multi.sv | 67 ++++++
 tb/tb_clint_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: address map, reset constants and address decode for clint_multi
package clint_pkg;
  localparam logic [15:0] MSIP_BASE = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO = 16'hBFF8;
  localparam logic [15:0] MTIME_HI = 16'hBFFC;
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef enum logic [2:0] {REG_NONE, REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_TIME_LO, REG_TIME_HI} reg_kind_e;
  typedef struct packed {
    reg_kind_e kind;
    logic [3:0] hart;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] a, input int nh);
    dec_t d;
    d = '{kind: REG_NONE, hart: 4'd0};
    if (a[1:0] == 2'b00) begin
      if ((a & ~32'h3F) == 32'(MSIP_BASE) && int'(a[5:2]) < nh)
        d = '{kind: REG_MSIP, hart: a[5:2]};
      else if ((a & ~32'h7F) == 32'(MTIMECMP_BASE) && int'(a[6:3]) < nh)
        d = '{kind: a[2] ? REG_CMP_HI : REG_CMP_LO, hart: a[6:3]};
      else if (a == 32'(MTIME_LO))
        d.kind = REG_TIME_LO;
      else if (a == 32'(MTIME_HI))
        d.kind = REG_TIME_HI;
    end
    return d;
  endfunction
endpackage

// File: rtl/clint_timebase.sv
// clint_timebase: prescaled 64-bit mtime counter with half-word writes
module clint_timebase #(
  parameter int TICK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_halt,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc;
  logic tick;
  assign tick = !timer_halt && presc == PW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      mtime <= '0;
    end else if (wr_lo || wr_hi) begin
      presc <= '0;
      if (wr_lo) mtime[31:0] <= wdata;
      if (wr_hi) mtime[63:32] <= wdata;
    end else if (!timer_halt) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) mtime <= mtime + 64'd1;
    end
  end
endmodule

// File: rtl/clint_multi.sv
// clint_multi: multi-hart core-local interruptor (mtime, msip, mtimecmp) on the gpi bus
module clint_multi
  import clint_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  parameter int TICK_DIV = 50,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gpi_read,
  input  logic                 gpi_write,
  input  logic [ADDR_W-1:0]    gpi_addr,
  input  logic [31:0]          gpi_wdata,
  output logic [31:0]          gpi_rdata,
  input  logic                 timer_halt,
  output logic [NUM_HARTS-1:0] intr_timer,
  output logic [NUM_HARTS-1:0] intr_soft
);
  dec_t d;
  logic [63:0] mtime;
  logic [63:0] cmp_sel;
  logic [63:0] mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic msip_sel;
  logic [31:0] rdata_c;
  assign d = decode(32'(gpi_addr), NUM_HARTS);
  assign intr_soft = msip;
  clint_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
    .clk(clk),
    .rst(rst),
    .timer_halt(timer_halt),
    .wr_lo(gpi_write && d.kind == REG_TIME_LO),
    .wr_hi(gpi_write && d.kind == REG_TIME_HI),
    .wdata(gpi_wdata),
    .mtime(mtime)
  );
  always_comb begin
    cmp_sel = '0;
    msip_sel = 1'b0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      cmp_sel = d.hart == 4'(i) ? mtimecmp[i] : cmp_sel;
      msip_sel = d.hart == 4'(i) ? msip[i] : msip_sel;
    end
    rdata_c = d.kind == REG_MSIP    ? {31'b0, msip_sel} :
              d.kind == REG_CMP_LO  ? cmp_sel[31:0] :
              d.kind == REG_CMP_HI  ? cmp_sel[63:32] :
              d.kind == REG_TIME_LO ? mtime[31:0] :
              d.kind == REG_TIME_HI ? mtime[63:32] : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gpi_rdata <= '0;
      msip <= '0;
      intr_timer <= '0;
      for (int i = 0; i < NUM_HARTS; i++) mtimecmp[i] <= MTIMECMP_RESET;
    end else begin
      if (gpi_read) gpi_rdata <= rdata_c;
      for (int i = 0; i < NUM_HARTS; i++) begin
        if (gpi_write && d.hart == 4'(i) && d.kind == REG_MSIP) msip[i] <= gpi_wdata[0];
        if (gpi_write && d.hart == 4'(i) && d.kind == REG_CMP_LO) mtimecmp[i][31:0] <= gpi_wdata;
        if (gpi_write && d.hart == 4'(i) && d.kind == REG_CMP_HI) mtimecmp[i][63:32] <= gpi_wdata;
        intr_timer[i] <= mtime >= mtimecmp[i];
      end
    end
  end
endmodule

// File: tb/tb_clint_multi.sv
// tb_clint_multi: randomized and directed checks of clint_multi against a behavioural model
module tb_clint_multi;
  localparam int NH = 2;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gpi_read = 1'b0;
  logic gpi_write = 1'b0;
  logic [15:0] gpi_addr = '0;
  logic [31:0] gpi_wdata = '0;
  logic [31:0] gpi_rdata;
  logic timer_halt = 1'b0;
  logic [NH-1:0] intr_timer;
  logic [NH-1:0] intr_soft;
  int checks = 0;
  int failures = 0;
  logic [63:0] m_time = '0;
  int m_pre = 0;
  logic [NH-1:0] m_msip = '0;
  logic [63:0] m_cmp [NH];
  logic [NH-1:0] m_it = '0;
  logic [31:0] m_rd = '0;
  logic [15:0] addrs [14] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008, 16'h400C,
                              16'h4010, 16'h4014, 16'hBFF8, 16'hBFFC, 16'h1234, 16'hC000, 16'h3FFC};
  clint_multi #(.NUM_HARTS(NH), .TICK_DIV(TD), .ADDR_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .gpi_read(gpi_read),
    .gpi_write(gpi_write),
    .gpi_addr(gpi_addr),
    .gpi_wdata(gpi_wdata),
    .gpi_rdata(gpi_rdata),
    .timer_halt(timer_halt),
    .intr_timer(intr_timer),
    .intr_soft(intr_soft)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mread(input int a);
    if (a % 4 != 0) return 32'b0;
    if (a < 4 * NH) return {31'b0, m_msip[a / 4]};
    if (a >= 'h4000 && a < 'h4000 + 8 * NH)
      return a % 8 == 0 ? m_cmp[(a - 'h4000) / 8][31:0] : m_cmp[(a - 'h4000) / 8][63:32];
    if (a == 'hBFF8) return m_time[31:0];
    if (a == 'hBFFC) return m_time[63:32];
    return 32'b0;
  endfunction
  task automatic cyc();
    logic [63:0] t;
    int p;
    int a;
    int h;
    bit tw;
    @(posedge clk);
    if (rst) begin
      m_time = '0;
      m_pre = 0;
      m_msip = '0;
      foreach (m_cmp[i]) m_cmp[i] = '1;
      m_it = '0;
      m_rd = '0;
    end else begin
      a = int'(gpi_addr);
      t = m_time;
      p = m_pre;
      tw = 0;
      if (gpi_read) m_rd = mread(a);
      for (int i = 0; i < NH; i++) m_it[i] = m_time >= m_cmp[i];
      if (gpi_write && a % 4 == 0) begin
        if (a < 4 * NH) m_msip[a / 4] = gpi_wdata[0];
        else if (a >= 'h4000 && a < 'h4000 + 8 * NH) begin
          h = (a - 'h4000) / 8;
          if (a % 8 == 0) m_cmp[h][31:0] = gpi_wdata;
          else m_cmp[h][63:32] = gpi_wdata;
        end else if (a == 'hBFF8) begin
          t[31:0] = gpi_wdata;
          tw = 1;
        end else if (a == 'hBFFC) begin
          t[63:32] = gpi_wdata;
          tw = 1;
        end
      end
      if (tw) p = 0;
      else if (!timer_halt) begin
        if (p == TD - 1) begin
          p = 0;
          t = t + 64'd1;
        end else p++;
      end
      m_time = t;
      m_pre = p;
    end
    #1;
    check("intr_timer", 64'(intr_timer), 64'(m_it));
    check("intr_soft", 64'(intr_soft), 64'(m_msip));
    check("gpi_rdata", 64'(gpi_rdata), 64'(m_rd));
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] v);
    gpi_write = 1'b1;
    gpi_addr = a;
    gpi_wdata = v;
    cyc();
    gpi_write = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    gpi_read = 1'b1;
    gpi_addr = a;
    cyc();
    gpi_read = 1'b0;
    check(tag, 64'(gpi_rdata), 64'(exp));
  endtask
  initial begin
    logic [63:0] v;
    int p;
    foreach (m_cmp[i]) m_cmp[i] = '1;
    repeat (3) cyc();
    check("rst_rdata", 64'(gpi_rdata), 64'd0);
    check("rst_intr_timer", 64'(intr_timer), 64'd0);
    rst = 1'b0;
    repeat (40) cyc();
    rdchk("t1_mtime", 16'hBFF8, 32'd10);
    check("t1_intr_timer", 64'(intr_timer), 64'd0);
    wr(16'h400C, 32'd0);
    wr(16'h4008, 32'd20);
    for (int i = 0; i < 200 && !intr_timer[1]; i++) cyc();
    check("t2_rise", 64'(intr_timer[1]), 64'd1);
    check("t2_hart0", 64'(intr_timer[0]), 64'd0);
    rdchk("t2_mtime_at_rise", 16'hBFF8, 32'd20);
    wr(16'h4008, 32'd100);
    check("t2_still_high", 64'(intr_timer[1]), 64'd1);
    cyc();
    check("t2_fall", 64'(intr_timer[1]), 64'd0);
    wr(16'h0004, 32'h0000_0001);
    check("t3_soft_set", 64'(intr_soft), 64'b10);
    rdchk("t3_read1", 16'h0004, 32'd1);
    wr(16'h0004, 32'hFFFF_FFFE);
    check("t3_soft_clr", 64'(intr_soft), 64'b00);
    rdchk("t3_read0", 16'h0004, 32'd0);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'h0);
    repeat (TD) cyc();
    rdchk("t4_carry_hi", 16'hBFFC, 32'd1);
    rdchk("t4_carry_lo", 16'hBFF8, 32'd0);
    for (int i = 0; i < 2 * TD && m_pre != TD - 1; i++) cyc();
    wr(16'hBFF8, 32'h0000_1234);
    rdchk("t4_write_wins", 16'hBFF8, 32'h0000_1234);
    rdchk("t4_hi_kept", 16'hBFFC, 32'd1);
    timer_halt = 1'b1;
    p = m_pre;
    v = m_time;
    repeat (20) cyc();
    rdchk("t5_halted", 16'hBFF8, v[31:0]);
    timer_halt = 1'b0;
    repeat (TD - 1 - p) cyc();
    rdchk("t5_pre_tick", 16'hBFF8, v[31:0]);
    rdchk("t5_tick", 16'hBFF8, v[31:0] + 32'd1);
    rdchk("t6_hart2_cmp", 16'h4010, 32'd0);
    rdchk("t6_unmapped", 16'h1234, 32'd0);
    wr(16'h4010, 32'd5);
    wr(16'h1234, 32'd7);
    wr(16'h0008, 32'd1);
    rdchk("t6_hart2_msip", 16'h0008, 32'd0);
    rdchk("t6_hart2_cmp_after", 16'h4010, 32'd0);
    rdchk("t6_msip0", 16'h0000, 32'd0);
    rdchk("t6_msip1", 16'h0004, 32'd0);
    rdchk("t6_cmp0_lo", 16'h4000, 32'hFFFF_FFFF);
    rdchk("t6_cmp1_lo", 16'h4008, 32'd100);
    rdchk("t6_cmp1_hi", 16'h400C, 32'd0);
    for (int i = 0; i < 400; i++) begin
      gpi_read = $urandom_range(0, 2) == 0;
      gpi_write = $urandom_range(0, 2) == 0;
      gpi_addr = addrs[$urandom_range(0, 13)];
      gpi_wdata = $urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 60);
      timer_halt = $urandom_range(0, 9) == 0;
      cyc();
    end
    gpi_read = 1'b0;
    gpi_write = 1'b0;
    timer_halt = 1'b0;
    wr(16'h0000, 32'd1);
    wr(16'h4004, 32'd0);
    wr(16'h4000, 32'd0);
    rdchk("pre_rst_read", 16'h0000, 32'd1);
    check("pre_rst_timer", 64'(intr_timer[0]), 64'd1);
    rst = 1'b1;
    gpi_read = 1'b1;
    gpi_write = 1'b1;
    gpi_addr = 16'h0004;
    gpi_wdata = 32'd1;
    cyc();
    gpi_read = 1'b0;
    gpi_write = 1'b0;
    check("mid_rst_rdata", 64'(gpi_rdata), 64'd0);
    check("mid_rst_timer", 64'(intr_timer), 64'd0);
    check("mid_rst_soft", 64'(intr_soft), 64'd0);
    rst = 1'b0;
    rdchk("post_rst_mtime", 16'hBFF8, 32'd0);
    rdchk("post_rst_cmp0", 16'h4000, 32'hFFFF_FFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
